// File: rtl/exec_stage.sv
// exec_stage: 16-bit execute stage (ALU, shifts, iterative MUL) driving the register-file write port.
// Define EXEC_FLAGS_EN to build the zero/negative/overflow flag registers; otherwise the flags read 0.
module exec_stage #(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [WIDTH-1:0]      imm,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [WIDTH-1:0]      dataWrite,
    output logic                  busy,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_v
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8, OP_SLT = 4'd9, OP_MUL = 4'd10, OP_LI = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [WIDTH-1:0]        r_mcand;
    logic [WIDTH-1:0]        r_mplier;
    logic [WIDTH-1:0]        r_acc;
    logic                    r_neg;
    logic [REG_ADDR_W-1:0]   r_rd;
    logic [WIDTH-1:0]        w_res;
    logic [WIDTH-1:0]        w_acc_next;
    logic [WIDTH-1:0]        w_mul_res;
    logic                    w_accept;
    logic                    w_wr;
    logic                    w_mul_done;

    assign w_accept   = in_valid && in_ready;
    assign w_wr       = (op <= OP_LI) && (op != OP_MUL);
    assign w_mul_done = (r_state == MUL) && (r_cnt == CW'(WIDTH - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_res  = r_neg ? -w_acc_next : w_acc_next;

    always_comb begin
        w_res = '0;
        case (op)
            OP_ADD:  w_res = A + B;
            OP_SUB:  w_res = A - B;
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            OP_SLL:  w_res = A << B[3:0];
            OP_SRL:  w_res = A >> B[3:0];
            OP_SRA:  w_res = $signed(A) >>> B[3:0];
            OP_ADDI: w_res = A + imm;
            OP_SLT:  w_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
            OP_LI:   w_res = imm;
            OP_CMP:  w_res = A - B;
            default: w_res = '0;
        endcase
    end

    // MUL works on magnitudes; the sign is reapplied to the low WIDTH bits on the last step.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            regWrite  <= 1'b0;
            rd        <= '0;
            dataWrite <= '0;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_rd      <= '0;
        end else begin
            regWrite <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && op == OP_MUL) begin
                        r_state  <= MUL;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= A[WIDTH-1] ? -A : A;
                        r_mplier <= B[WIDTH-1] ? -B : B;
                        r_neg    <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_rd     <= rd_in;
                    end else if (w_accept && w_wr) begin
                        regWrite  <= (rd_in != '0);
                        rd        <= rd_in;
                        dataWrite <= w_res;
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_done) begin
                        r_state   <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        regWrite  <= (r_rd != '0);
                        rd        <= r_rd;
                        dataWrite <= w_mul_res;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef EXEC_FLAGS_EN
    logic w_v;
    logic w_fl;

    assign w_fl = w_wr || (op == OP_CMP);

    always_comb begin
        w_v = 1'b0;
        case (op)
            OP_ADD:          w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            OP_SUB, OP_CMP:  w_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            OP_ADDI:         w_v = (A[WIDTH-1] == imm[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            default:         w_v = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else if (w_mul_done) begin
            flag_z <= (w_mul_res == '0);
            flag_n <= w_mul_res[WIDTH-1];
            flag_v <= 1'b0;
        end else if (r_state == IDLE && w_accept && w_fl) begin
            flag_z <= (w_res == '0);
            flag_n <= w_res[WIDTH-1];
            flag_v <= w_v;
        end
    end
`else
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
    assign flag_v = 1'b0;
`endif
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed tests for exec_stage; flag expectations follow EXEC_FLAGS_EN.
module tb_exec_stage;
    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [3:0]  rd_in = '0;
    logic [15:0] A = '0, B = '0, imm = '0;
    logic        regWrite;
    logic [3:0]  rd;
    logic [15:0] dataWrite;
    logic        busy, flag_z, flag_n, flag_v;
    int          checks = 0;
    int          failures = 0;

    exec_stage dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rd_in(rd_in), .A(A), .B(B), .imm(imm), .regWrite(regWrite), .rd(rd),
        .dataWrite(dataWrite), .busy(busy), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [3:0] r, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] im);
        in_valid = 1'b1; op = o; rd_in = r; A = a; B = b; imm = im;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        checks++;
        if ({in_ready, regWrite, rd, dataWrite, busy, flag_z, flag_n, flag_v} !== {1'b1, 1'b0, 4'd0, 16'd0, 4'b0000}) begin
            failures++;
            $display("FAIL reset: ready=%b wr=%b rd=%0d dw=%h busy=%b flags=%b%b%b, expected ready=1 rest 0",
                     in_ready, regWrite, rd, dataWrite, busy, flag_z, flag_n, flag_v);
        end
    endtask

    task automatic test_add_overflow();
        drive(4'd0, 4'd3, 16'h7FFF, 16'h0001, 16'h0);
        checks++;
        if ({regWrite, rd, dataWrite} !== {1'b1, 4'd3, 16'h8000}) begin
            failures++;
            $display("FAIL add_write: wr=%b rd=%0d dw=%h, expected wr=1 rd=3 dw=8000", regWrite, rd, dataWrite);
        end
`ifdef EXEC_FLAGS_EN
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b011) begin
            failures++;
            $display("FAIL add_flags: znv=%b%b%b, expected 011", flag_z, flag_n, flag_v);
        end
`endif
        step();
        checks++;
        if (regWrite !== 1'b0) begin
            failures++;
            $display("FAIL add_pulse: wr=%b one cycle later, expected 0", regWrite);
        end
    endtask

    task automatic test_alu_back_to_back();
        logic [3:0]  ops [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd9, 4'd11};
        logic [15:0] as  [9] = '{16'h0005, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0003, 16'h0010, 16'hFFFF, 16'h0001, 16'h0};
        logic [15:0] bs  [9] = '{16'h0007, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h0004, 16'h0, 16'h0001, 16'hFFFF, 16'h0};
        logic [15:0] ims [9] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h1234};
        logic [15:0] exp [9] = '{16'hFFFE, 16'h3030, 16'hFCFC, 16'hCCCC, 16'h0030, 16'h000F, 16'h0001, 16'h0000, 16'h1234};
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; op = ops[i]; rd_in = 4'(i + 1); A = as[i]; B = bs[i]; imm = ims[i];
            step();
            checks++;
            if ({regWrite, rd, dataWrite} !== {1'b1, 4'(i + 1), exp[i]}) begin
                failures++;
                $display("FAIL alu_op%0d: wr=%b rd=%0d dw=%h, expected wr=1 rd=%0d dw=%h",
                         ops[i], regWrite, rd, dataWrite, i + 1, exp[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mul();
        int bad = 0;
        drive(4'd10, 4'd5, 16'd300, 16'hFFFE, 16'h0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin in_valid = 1'b1; op = 4'd0; rd_in = 4'd7; A = 16'd1; B = 16'd1; end
            if (i == 6) in_valid = 1'b0;
            if (in_ready !== 1'b0 || busy !== 1'b1 || regWrite !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mul_busy: %0d cycles with ready/busy/wr wrong during iteration", bad);
        end
        checks++;
        if ({regWrite, rd, dataWrite, in_ready, busy} !== {1'b1, 4'd5, 16'hFDA8, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mul_result: wr=%b rd=%0d dw=%h ready=%b busy=%b, expected 1 5 fda8 1 0",
                     regWrite, rd, dataWrite, in_ready, busy);
        end
        step();
        checks++;
        if (regWrite !== 1'b0) begin
            failures++;
            $display("FAIL mul_ignored: wr=%b rd=%0d after MUL, expected no write", regWrite, rd);
        end
    endtask

    task automatic test_mul_corner();
        drive(4'd10, 4'd6, 16'h8000, 16'hFFFF, 16'h0);
        for (int i = 0; i < 40 && regWrite !== 1'b1; i++) step();
        checks++;
        if ({regWrite, rd, dataWrite} !== {1'b1, 4'd6, 16'h8000}) begin
            failures++;
            $display("FAIL mul_corner: wr=%b rd=%0d dw=%h, expected 1 6 8000", regWrite, rd, dataWrite);
        end
`ifdef EXEC_FLAGS_EN
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b010) begin
            failures++;
            $display("FAIL mul_corner_flags: znv=%b%b%b, expected 010", flag_z, flag_n, flag_v);
        end
`endif
    endtask

    task automatic test_rd0();
        int writes = 0;
        drive(4'd0, 4'd0, 16'd5, 16'd6, 16'h0);
        if (regWrite !== 1'b0) writes++;
        checks++;
        if (dataWrite !== 16'h000B || rd !== 4'd0) begin
            failures++;
            $display("FAIL rd0_debug: rd=%0d dw=%h, expected 0 000b", rd, dataWrite);
        end
`ifdef EXEC_FLAGS_EN
        checks++;
        if (flag_z !== 1'b0) begin
            failures++;
            $display("FAIL rd0_flag_z: z=%b, expected 0", flag_z);
        end
`endif
        for (int i = 0; i < 3; i++) begin step(); if (regWrite !== 1'b0) writes++; end
        checks++;
        if (writes != 0) begin
            failures++;
            $display("FAIL rd0_write: %0d strobes seen, expected 0", writes);
        end
    endtask

    task automatic test_reset_mid_mul();
        int writes = 0;
        drive(4'd10, 4'd9, 16'd3, 16'd3, 16'h0);
        for (int i = 0; i < 4; i++) begin if (regWrite !== 1'b0) writes++; step(); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mul_state: ready=%b busy=%b, expected 1 0", in_ready, busy);
        end
        for (int i = 0; i < 24; i++) begin if (regWrite !== 1'b0) writes++; step(); end
        checks++;
        if (writes != 0) begin
            failures++;
            $display("FAIL reset_mul_write: %0d strobes after abort, expected 0", writes);
        end
    endtask

    task automatic test_shift_back_to_back();
        in_valid = 1'b1; op = 4'd7; rd_in = 4'd1; A = 16'h8000; B = 16'd4;
        step();
        checks++;
        if ({regWrite, rd, dataWrite} !== {1'b1, 4'd1, 16'hF800}) begin
            failures++;
            $display("FAIL sra: wr=%b rd=%0d dw=%h, expected 1 1 f800", regWrite, rd, dataWrite);
        end
        op = 4'd6; rd_in = 4'd2;
        step();
        in_valid = 1'b0;
        checks++;
        if ({regWrite, rd, dataWrite} !== {1'b1, 4'd2, 16'h0800}) begin
            failures++;
            $display("FAIL srl: wr=%b rd=%0d dw=%h, expected 1 2 0800", regWrite, rd, dataWrite);
        end
    endtask

    task automatic test_cmp_nop();
        drive(4'd11, 4'd1, 16'h0, 16'h0, 16'h8001);
        drive(4'd12, 4'd4, 16'd7, 16'd7, 16'h0);
        checks++;
        if (regWrite !== 1'b0) begin
            failures++;
            $display("FAIL cmp_write: wr=%b, expected 0", regWrite);
        end
`ifdef EXEC_FLAGS_EN
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b100) begin
            failures++;
            $display("FAIL cmp_flags: znv=%b%b%b, expected 100", flag_z, flag_n, flag_v);
        end
        drive(4'd13, 4'd4, 16'h8000, 16'h1, 16'h0);
        checks++;
        if ({regWrite, flag_z, flag_n, flag_v} !== 4'b0100) begin
            failures++;
            $display("FAIL nop: wr=%b znv=%b%b%b, expected wr=0 znv=100", regWrite, flag_z, flag_n, flag_v);
        end
`else
        checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b000) begin
            failures++;
            $display("FAIL cmp_flags_off: znv=%b%b%b, expected 000", flag_z, flag_n, flag_v);
        end
        drive(4'd13, 4'd4, 16'h8000, 16'h1, 16'h0);
        checks++;
        if (regWrite !== 1'b0) begin
            failures++;
            $display("FAIL nop: wr=%b, expected 0", regWrite);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_alu_back_to_back();
        test_mul();
        test_mul_corner();
        test_rd0();
        test_reset_mid_mul();
        test_shift_back_to_back();
        test_cmp_nop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
